// File: rtl/doorlock_pkg.sv
// rtl/doorlock_pkg.sv - door lock state encoding, display codes and shared constants
// PWSET state exists only when DOORLOCK_PWCHANGE_EN is defined.
package doorlock_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  // State encoding kept as plain constants so older tools can share it.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_ENTRY   = 3'd1;
  localparam state_t ST_CHECK   = 3'd2;
  localparam state_t ST_OPEN    = 3'd3;
  localparam state_t ST_FAIL    = 3'd4;
  localparam state_t ST_LOCKOUT = 3'd5;
`ifdef DOORLOCK_PWCHANGE_EN
  localparam state_t ST_PWSET   = 3'd6;
`endif

  localparam logic [1:0] DISP_DASH  = 2'b00;
  localparam logic [1:0] DISP_OPEN  = 2'b01;
  localparam logic [1:0] DISP_CLOSE = 2'b10;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/doorlock_timer.sv
// rtl/doorlock_timer.sv - loadable down-counter, done is high on the last counted cycle
module doorlock_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == W'(1));

endmodule

// File: rtl/doorlock_ctrl.sv
// rtl/doorlock_ctrl.sv - keypad door lock controller
// Define DOORLOCK_PWCHANGE_EN to allow changing the password from the OPEN state.
module doorlock_ctrl
  import doorlock_pkg::*;
#(
  parameter int                          PW_LEN         = 4,
  parameter logic [PW_LEN*DIGIT_W-1:0]   DEFAULT_PW     = 16'h1234,
  parameter int                          OPEN_CYCLES    = 8,
  parameter int                          FAIL_CYCLES    = 4,
  parameter int                          LOCKOUT_CYCLES = 16,
  parameter int                          MAX_FAIL       = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         digit_valid,
  input  logic [3:0]   digit,
  input  logic         clear,
  input  logic         set_pw,
  output logic [1:0]   disp_state,
  output logic         door_open,
  output logic         alarm,
  output logic [2:0]   entry_cnt
);

  localparam int PW_W = PW_LEN * DIGIT_W;
  localparam int TW   = $clog2(max3(OPEN_CYCLES, FAIL_CYCLES, LOCKOUT_CYCLES) + 1);
  localparam int FW   = $clog2(MAX_FAIL + 1);

  state_t          state_q, state_d;
  logic [PW_W-1:0] buf_q, buf_d, buf_src, buf_shift, pw;
  logic [2:0]      cnt_q, cnt_d, cnt_inc;
  logic [FW-1:0]   fail_q, fail_d, fail_inc;
  logic [1:0]      disp_q, disp_d;
  logic            door_q, door_d, alarm_q, alarm_d;
  logic            digit_ok, last_digit;
  logic            tmr_load, tmr_done;
  logic [TW-1:0]   tmr_val;

`ifdef DOORLOCK_PWCHANGE_EN
  logic [PW_W-1:0] pw_q, pw_d;
  assign pw = pw_q;
`else
  logic unused_set_pw;
  assign unused_set_pw = set_pw;
  assign pw = DEFAULT_PW;
`endif

  assign digit_ok   = digit_valid && (digit <= DIGIT_MAX);
  // A fresh entry always starts from an empty buffer, whatever IDLE holds.
  assign buf_src    = (state_q == ST_IDLE) ? '0 : buf_q;
  assign buf_shift  = PW_W'({buf_src, digit});
  assign cnt_inc    = cnt_q + 3'd1;
  assign last_digit = (cnt_inc == 3'(PW_LEN));
  assign fail_inc   = (fail_q >= FW'(MAX_FAIL)) ? fail_q : fail_q + 1'b1;

  doorlock_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    fail_d   = fail_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
`ifdef DOORLOCK_PWCHANGE_EN
    pw_d     = pw_q;
`endif
    case (state_q)
      ST_IDLE, ST_ENTRY: begin
        if ((state_q == ST_ENTRY) && clear) begin
          state_d = ST_IDLE;
          buf_d   = '0;
          cnt_d   = '0;
        end else if (digit_ok) begin
          buf_d = buf_shift;
          if (last_digit) begin
            cnt_d   = '0;
            state_d = ST_CHECK;
          end else begin
            cnt_d   = cnt_inc;
            state_d = ST_ENTRY;
          end
        end
      end
      ST_CHECK: begin
        buf_d    = '0;
        tmr_load = 1'b1;
        if (buf_q == pw) begin
          state_d = ST_OPEN;
          fail_d  = '0;
          tmr_val = TW'(OPEN_CYCLES);
        end else begin
          fail_d = fail_inc;
          if (fail_inc >= FW'(MAX_FAIL)) begin
            state_d = ST_LOCKOUT;
            tmr_val = TW'(LOCKOUT_CYCLES);
          end else begin
            state_d = ST_FAIL;
            tmr_val = TW'(FAIL_CYCLES);
          end
        end
      end
      ST_OPEN: begin
`ifdef DOORLOCK_PWCHANGE_EN
        if (set_pw) begin
          state_d = ST_PWSET;
          buf_d   = '0;
          cnt_d   = '0;
        end else if (tmr_done) begin
          state_d = ST_IDLE;
        end
`else
        if (tmr_done) state_d = ST_IDLE;
`endif
      end
      ST_FAIL: begin
        if (tmr_done) state_d = ST_IDLE;
      end
      ST_LOCKOUT: begin
        if (tmr_done) begin
          state_d = ST_IDLE;
          fail_d  = '0;
        end
      end
`ifdef DOORLOCK_PWCHANGE_EN
      ST_PWSET: begin
        if (clear) begin
          state_d = ST_IDLE;
          buf_d   = '0;
          cnt_d   = '0;
        end else if (digit_ok) begin
          if (last_digit) begin
            pw_d    = buf_shift;
            buf_d   = '0;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            buf_d = buf_shift;
            cnt_d = cnt_inc;
          end
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        buf_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    door_d  = (state_d == ST_OPEN);
    alarm_d = (state_d == ST_LOCKOUT);
    case (state_d)
      ST_OPEN:             disp_d = DISP_OPEN;
      ST_FAIL, ST_LOCKOUT: disp_d = DISP_CLOSE;
      default:             disp_d = DISP_DASH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      fail_q  <= '0;
      disp_q  <= DISP_DASH;
      door_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      disp_q  <= disp_d;
      door_q  <= door_d;
      alarm_q <= alarm_d;
    end
  end

`ifdef DOORLOCK_PWCHANGE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pw_q <= DEFAULT_PW;
    end else begin
      pw_q <= pw_d;
    end
  end
`endif

  assign disp_state = disp_q;
  assign door_open  = door_q;
  assign alarm      = alarm_q;
  assign entry_cnt  = cnt_q;

endmodule
